bsg_cache_dma_mem_model: RTL and testbench
==========================================

# bsg_cache_dma_mem_model

Behavioral main-memory model that sits directly downstream of a `bsg_cache` DMA port in the cache test benches. It consumes DMA packets and serves whole-block transfers:
- a read packet streams `block_size_in_words_p` words back to the cache;
- a write packet absorbs `block_size_in_words_p` evict words into a local word array.

One instance is used per cache; it replaces an external DRAM so that trace-replay tests run self-contained.

## Interface
Parameters:
- `addr_width_p`, no default (`BSG_INV_PARAM`): byte address width of the DMA packet.
- `data_width_p`, no default: word width; must be a power of two and ≥ 8.
- `block_size_in_words_p`, no default: beats per transfer; must be a power of two and ≥ 1.
- `mem_els_p`, default 1024: number of words in the array; must be a power of two and ≥ `block_size_in_words_p`.
- `latency_p`, default 4: added cycles before a transfer starts; must be ≥ 1; used only with the latency macro.
- `dma_pkt_width_lp`, localparam = `addr_width_p`+1: packet layout is {write_not_read, addr}.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_n_i`  in  1  asynchronous active-low reset.
- `dma_pkt_i`  in  `dma_pkt_width_lp`  DMA request.
- `dma_pkt_v_i`  in  1  request valid.
- `dma_pkt_yumi_o`  out  1  request consumed this cycle.
- `dma_data_o`  out  `data_width_p`  read-return word.
- `dma_data_v_o`  out  1  read word valid.
- `dma_data_ready_and_i`  in  1  cache accepts the read word.
- `dma_data_i`  in  `data_width_p`  write (evict) word.
- `dma_data_v_i`  in  1  write word valid.
- `dma_data_yumi_o`  out  1  write word consumed.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- State machine states:
  - IDLE: `dma_pkt_yumi_o` = `dma_pkt_v_i`. On a consumed packet, latch `base` and `write_not_read`, clear the beat counter, then go to DELAY (macro on) or to READ/WRITE (macro off).
  - DELAY: count down from `latency_p`-1; at 0, go to READ if `write_not_read`=0, else WRITE.
  - READ: `dma_data_v_o`=1, `dma_data_o` = mem[`base`+k]. The counter k advances when `dma_data_ready_and_i` is high; after beat `block_size_in_words_p`-1 is accepted, return to IDLE.
  - WRITE: `dma_data_yumi_o` = `dma_data_v_i`. On yumi, write mem[`base`+k] ← `dma_data_i` and advance k; after the last beat, return to IDLE.
- Address rules:
  - Word index = addr >> log2(`data_width_p`/8), taken modulo `mem_els_p` (upper bits ignored, so addresses wrap).
  - `base` = word index with the low log2(`block_size_in_words_p`) bits cleared. Unaligned packet addresses are therefore treated as block-aligned.
- Beat counter: width log2(`block_size_in_words_p`), minimum 1 bit. Beats go in ascending word order with no critical-word-first.
- Read-only outputs are 0 outside READ; write-only outputs are 0 outside WRITE. `dma_data_o` is 0 when `dma_data_v_o`=0.
- A packet presented while busy stays unconsumed until IDLE. It is never dropped or reordered.
- Write data presented outside WRITE is ignored and not consumed. A write burst holds no read data.

## Timing
- Reset:
  - State=IDLE; all outputs 0 (`dma_pkt_yumi_o` is forced 0 while `reset_n_i`=0).
  - Counters 0; array cleared to all-zero words.
- Reset asserted mid-burst aborts the transfer immediately and asynchronously. Partially written words keep no guarantee; the array is cleared.
- Macro off: packet consumed at cycle 0; first read beat is valid at cycle 1. With continuous ready, the last beat is at cycle `block_size_in_words_p` and the next packet can be consumed at cycle `block_size_in_words_p`+1.
- Macro on: the first beat/yumi is at cycle `latency_p`+1.
- Writes: the word written on a yumi edge is readable by any later read packet.
- Back-to-back packets always have at least one IDLE cycle between them.

## Configuration
- `BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN` defined:
  - DELAY state is compiled in.
  - Every transfer waits `latency_p` cycles after packet consumption before the first beat.
- `BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN` undefined:
  - DELAY state and its counter are absent.
  - Transfers start the cycle after consumption; `latency_p` is ignored.

## Test plan
Bench settings: `data_width_p`=32, `block_size_in_words_p`=4, `mem_els_p`=64; macro off unless stated.
1. Write packet {1, 0x40} with words 0xA0..0xA3, then read packet {1'b0, 0x40} → read beats 0xA0, 0xA1, 0xA2, 0xA3 in order, first beat the cycle after consumption.
2. Read packet {1'b0, 0x80} after reset → four beats of 0x0; `busy_o` high for exactly 4 cycles.
3. Read with `dma_data_ready_and_i` toggling 1,0,0,1,... → each beat is held stable while not ready; exactly 4 beats accepted; no duplicates or skips.
4. Second packet asserted during a write burst → `dma_pkt_yumi_o` stays 0 until IDLE, then consumed; its data is correct.
5. Write to 0x40 then read from 0x140 (wraps modulo 64 words) → returns the 0x40 data. Reset pulse mid-read → `dma_data_v_o` drops the same cycle and a later read returns zeros.
6. Macro on, `latency_p`=4 → first read beat exactly at cycle 5 after consumption; write yumi is likewise first possible at cycle 5.

Source files
------------

// File: rtl/bsg_cache_dma_mem_model.sv
// Block-transfer main-memory model behind a bsg_cache DMA port; serves whole-block reads and writes.
// Latency: first beat one cycle after packet consumption (latency_p+1 with BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN).
// Backpressure: packets wait in IDLE until consumed; read beats hold until ready; write beats taken on valid.
module bsg_cache_dma_mem_model #(
    // Defaults are placeholders only; every instance is expected to set these.
    parameter int addr_width_p          = 32,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 4,
    parameter int mem_els_p             = 1024,
    parameter int latency_p             = 4,
    localparam int dma_pkt_width_lp     = addr_width_p + 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
    input  logic                        dma_pkt_v_i,
    output logic                        dma_pkt_yumi_o,
    output logic [data_width_p-1:0]     dma_data_o,
    output logic                        dma_data_v_o,
    input  logic                        dma_data_ready_and_i,
    input  logic [data_width_p-1:0]     dma_data_i,
    input  logic                        dma_data_v_i,
    output logic                        dma_data_yumi_o,
    output logic                        busy_o
);

    localparam int byte_off_lp = $clog2(data_width_p / 8);
    localparam int idx_w_lp    = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int cnt_w_lp    = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
`ifdef BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN
    localparam int dly_w_lp    = (latency_p > 1) ? $clog2(latency_p) : 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
`ifdef BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN
        , DELAY = 2'd3
`endif
    } state_e;

    state_e                  state_q, state_d;
    logic [idx_w_lp-1:0]     base_q, base_d;
    logic                    wnr_q, wnr_d;
    logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
    logic [data_width_p-1:0] mem_q [mem_els_p];
    logic [data_width_p-1:0] mem_d [mem_els_p];
`ifdef BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN
    logic [dly_w_lp-1:0]     dly_q, dly_d;
`endif

    // Packet decode: word index wraps modulo the array, low beat bits forced to zero (block aligned).
    logic [idx_w_lp-1:0] pkt_idx;
    logic [idx_w_lp-1:0] pkt_base;
    logic [idx_w_lp-1:0] beat_idx;
    logic                last_beat;

    // Address decode and current beat position within the block.
    always_comb begin
        pkt_idx   = idx_w_lp'(dma_pkt_i[addr_width_p-1:0] >> byte_off_lp);
        pkt_base  = pkt_idx & ~idx_w_lp'(block_size_in_words_p - 1);
        beat_idx  = base_q | idx_w_lp'(cnt_q);
        last_beat = (cnt_q == cnt_w_lp'(block_size_in_words_p - 1));
    end

    // Next-state, datapath updates and outputs of the transfer FSM.
    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        wnr_d           = wnr_q;
        cnt_d           = cnt_q;
        mem_d           = mem_q;
`ifdef BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN
        dly_d           = dly_q;
`endif
        dma_pkt_yumi_o  = 1'b0;
        dma_data_o      = '0;
        dma_data_v_o    = 1'b0;
        dma_data_yumi_o = 1'b0;
        busy_o          = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // Gate with reset so nothing looks consumed while the block is held in reset.
                dma_pkt_yumi_o = dma_pkt_v_i & reset_n_i;
                if (dma_pkt_v_i) begin
                    base_d = pkt_base;
                    wnr_d  = dma_pkt_i[addr_width_p];
                    cnt_d  = '0;
`ifdef BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN
                    dly_d   = dly_w_lp'(latency_p - 1);
                    state_d = DELAY;
`else
                    state_d = dma_pkt_i[addr_width_p] ? WRITE : READ;
`endif
                end
            end
`ifdef BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN
            DELAY: begin
                if (dly_q == '0) begin
                    state_d = wnr_q ? WRITE : READ;
                end else begin
                    dly_d = dly_q - dly_w_lp'(1);
                end
            end
`endif
            READ: begin
                dma_data_v_o = 1'b1;
                dma_data_o   = mem_q[beat_idx];
                if (dma_data_ready_and_i) begin
                    cnt_d = cnt_q + cnt_w_lp'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i) begin
                    mem_d[beat_idx] = dma_data_i;
                    cnt_d           = cnt_q + cnt_w_lp'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and array registers; reset aborts any transfer and clears the array.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            wnr_q   <= 1'b0;
            cnt_q   <= '0;
            mem_q   <= '{default: '0};
`ifdef BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN
            dly_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            wnr_q   <= wnr_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
`ifdef BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN
            dly_q   <= dly_d;
`endif
        end
    end

endmodule

// File: tb/tb_bsg_cache_dma_mem_model.sv
// Directed bench for bsg_cache_dma_mem_model: table of block transfers plus hand sequences
// for held packets and reset mid-read. Works with or without BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN.
module tb_bsg_cache_dma_mem_model;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int BLK = 4;
    localparam int ELS = 64;
    localparam int LAT = 4;
`ifdef BSG_CACHE_DMA_MEM_MODEL_LATENCY_EN
    localparam int EXP_LAT = LAT + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW:0]   pkt;
    logic          pkt_v;
    logic          pkt_yumi;
    logic [DW-1:0] rdata;
    logic          rdata_v;
    logic          ready;
    logic [DW-1:0] wdata;
    logic          wdata_v;
    logic          wdata_yumi;
    logic          busy;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bsg_cache_dma_mem_model #(
        .addr_width_p(AW), .data_width_p(DW), .block_size_in_words_p(BLK),
        .mem_els_p(ELS), .latency_p(LAT)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v), .dma_pkt_yumi_o(pkt_yumi),
        .dma_data_o(rdata), .dma_data_v_o(rdata_v), .dma_data_ready_and_i(ready),
        .dma_data_i(wdata), .dma_data_v_i(wdata_v), .dma_data_yumi_o(wdata_yumi),
        .busy_o(busy)
    );

    typedef struct {
        logic                wr;
        logic [AW-1:0]       addr;
        logic [15:0]         pat;   // ready pattern, one bit per valid read cycle
        logic [3:0][DW-1:0]  data;  // write words / expected read words
        logic                bz;    // also check busy duration (continuous ready only)
    } vec_t;

    vec_t vecs [7];

    function automatic logic [3:0][DW-1:0] words(input logic [DW-1:0] b);
        logic [3:0][DW-1:0] r;
        for (int k = 0; k < 4; k++) r[k] = b + DW'(k);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Call at a falling edge; returns at the falling edge after the consuming rising edge.
    task automatic send_pkt(input logic wr, input logic [AW-1:0] a, output int tries);
        pkt   = {wr, a};
        pkt_v = 1'b1;
        tries = 0;
        #1;
        while (!pkt_yumi && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        chk("pkt_consumed", pkt_yumi, 1);
        @(posedge clk);
        @(negedge clk);
        pkt_v = 1'b0;
    endtask

    task automatic do_read(input string nm, input logic [AW-1:0] a, input logic [3:0][DW-1:0] exp,
                           input logic [15:0] pat, input bit chk_busy, input bit chk_now);
        int tries, cyc, k, vidx, first, busyc;
        send_pkt(1'b0, a, tries);
        if (chk_now) chk({nm, " wait"}, tries, 0);
        cyc = 1; k = 0; vidx = 0; first = 0; busyc = 0;
        while (k < 4 && cyc < 100) begin
            #1;
            if (busy) busyc++;
            if (rdata_v) begin
                if (first == 0) first = cyc;
                chk($sformatf("%s beat%0d", nm, k), rdata, exp[k]);
                ready = (vidx < 16) ? pat[vidx] : 1'b1;
                vidx++;
                if (ready) k++;
            end else begin
                ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        ready = 1'b0;
        #1;
        chk({nm, " beats"}, k, 4);
        chk({nm, " first"}, first, EXP_LAT);
        chk({nm, " idle_v"}, {busy, rdata_v}, 0);
        chk({nm, " idle_d"}, rdata, 0);
        if (chk_busy) chk({nm, " busy_cycles"}, busyc, EXP_LAT + 3);
    endtask

    task automatic do_write(input string nm, input logic [AW-1:0] a, input logic [3:0][DW-1:0] w,
                            input bit hold, input logic [AW:0] hold_pkt);
        int tries, cyc, k, first, viol;
        send_pkt(1'b1, a, tries);
        cyc = 1; k = 0; first = 0; viol = 0;
        while (k < 4 && cyc < 100) begin
            wdata_v = 1'b1;
            wdata   = w[k];
            if (hold) begin
                pkt   = hold_pkt;
                pkt_v = 1'b1;
            end
            #1;
            if (hold && pkt_yumi) viol++;
            if (rdata_v || rdata != '0) viol++;
            if (wdata_yumi) begin
                if (first == 0) first = cyc;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        wdata_v = 1'b0;
        #1;
        chk({nm, " beats"}, k, 4);
        chk({nm, " first"}, first, EXP_LAT);
        chk({nm, " violations"}, viol, 0);
        chk({nm, " idle"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tries, cnt;
        vecs[0] = '{wr: 1'b1, addr: 12'h040, pat: 16'hFFFF, data: words(32'hA0), bz: 1'b0};
        vecs[1] = '{wr: 1'b0, addr: 12'h040, pat: 16'hFFFF, data: words(32'hA0), bz: 1'b1};
        vecs[2] = '{wr: 1'b0, addr: 12'h080, pat: 16'hFFFF, data: '0,            bz: 1'b1};
        vecs[3] = '{wr: 1'b0, addr: 12'h040, pat: 16'h0249, data: words(32'hA0), bz: 1'b0};
        vecs[4] = '{wr: 1'b1, addr: 12'h10C, pat: 16'hFFFF, data: words(32'hC0), bz: 1'b0};
        vecs[5] = '{wr: 1'b0, addr: 12'h000, pat: 16'hFFFF, data: words(32'hC0), bz: 1'b1};
        vecs[6] = '{wr: 1'b0, addr: 12'h140, pat: 16'h0249, data: words(32'hA0), bz: 1'b0};

        // Reset state, with requests presented so forced-zero handshakes are visible.
        reset_n = 1'b0;
        pkt     = {1'b0, 12'h040};
        pkt_v   = 1'b1;
        ready   = 1'b1;
        wdata   = 32'hDEAD_BEEF;
        wdata_v = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst pkt_yumi", pkt_yumi, 0);
        chk("rst data_v", rdata_v, 0);
        chk("rst data", rdata, 0);
        chk("rst data_yumi", wdata_yumi, 0);
        chk("rst busy", busy, 0);
        @(negedge clk);
        pkt_v   = 1'b0;
        ready   = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("idle data_yumi", wdata_yumi, 0);
        @(negedge clk);
        wdata_v = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) do_write($sformatf("v%0d", i), vecs[i].addr, vecs[i].data, 1'b0, '0);
            else do_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].data, vecs[i].pat, vecs[i].bz, 1'b0);
        end

        // Read packet held during a write burst is consumed in the first IDLE cycle.
        do_write("hold_wr", 12'h080, words(32'hD0), 1'b1, {1'b0, 12'h080});
        do_read("held_rd", 12'h080, words(32'hD0), 16'hFFFF, 1'b0, 1'b1);

        // Reset in the middle of a read burst.
        send_pkt(1'b0, 12'h040, tries);
        cnt = 0;
        while (cnt < 20) begin
            #1;
            if (rdata_v) break;
            @(negedge clk);
            cnt++;
        end
        chk("midrst started", rdata_v, 1);
        ready = 1'b1;
        @(negedge clk);
        pkt   = {1'b0, 12'h040};
        pkt_v = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst data_v", rdata_v, 0);
        chk("midrst data", rdata, 0);
        chk("midrst busy", busy, 0);
        chk("midrst pkt_yumi", pkt_yumi, 0);
        @(negedge clk);
        reset_n = 1'b1;
        pkt_v   = 1'b0;
        ready   = 1'b0;
        do_read("post_rst", 12'h040, '0, 16'hFFFF, 1'b1, 1'b0);
        do_read("post_rst2", 12'h080, '0, 16'hFFFF, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
